// File: rtl/spike_hs_pkg.sv
// spike_hs_pkg: shared handshake FSM states and default sizing for the spike receiver.
package spike_hs_pkg;
    typedef enum logic {IDLE, ACK_HI} hs_state_e;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_FIFO_DEPTH = 4;
endpackage

// File: rtl/spike_hs_sync.sv
// spike_hs_sync: STAGES-flop synchronizer with asynchronous reset to 0.
module spike_hs_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic [STAGES-1:0] sync_q, sync_d;
    assign sync_d = {sync_q[STAGES-2:0], d_i};
    assign q_o    = sync_q[STAGES-1];
    always_ff @(posedge clk or posedge rst)
        if (rst) sync_q <= '0;
        else     sync_q <= sync_d;
endmodule

// File: rtl/spike_hs_rx.sv
// spike_hs_rx: 4-phase bundled-data receiver from an async Muller pipeline into a clocked FIFO.
// Define SPIKE_HS_RX_SYNC3_EN for a 3-flop req_i synchronizer (default is 2 flops).
module spike_hs_rx
    import spike_hs_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_i,
    input  logic [DATA_W-1:0]             data_i,
    output logic                          ack_o,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [DATA_W-1:0]             out_data_o,
    output logic [$clog2(FIFO_DEPTH):0]   fill_o
);
`ifdef SPIKE_HS_RX_SYNC3_EN
    localparam int SYNC_STAGES = 3;
`else
    localparam int SYNC_STAGES = 2;
`endif
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = AW + 1;
    localparam logic [FW-1:0] FULL = FW'(FIFO_DEPTH);

    logic              req_s, push, pop;
    hs_state_e         state_q, state_d;
    logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [FW-1:0]     fill_q, fill_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

    spike_hs_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (req_i),
        .q_o (req_s)
    );

    assign ack_o       = state_q == ACK_HI;
    assign out_valid_o = fill_q != '0;
    assign out_data_o  = mem_q[rptr_q];
    assign fill_o      = fill_q;

    // A full FIFO withholds the capture, which keeps ack_o low and stalls the sender.
    always_comb begin
        push    = state_q == IDLE && req_s && fill_q < FULL;
        pop     = out_valid_o && out_ready_i;
        state_d = state_q == IDLE ? (push ? ACK_HI : IDLE) : (req_s ? ACK_HI : IDLE);
        wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
        fill_d  = fill_q + FW'(push) - FW'(pop);
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            fill_q  <= fill_d;
        end

    always_ff @(posedge clk)
        if (push) mem_q[wptr_q] <= data_i;
endmodule

// File: tb/tb_spike_hs_rx.sv
// tb_spike_hs_rx: directed and randomized checks of spike_hs_rx against a queue model of the receive buffer.
module tb_spike_hs_rx;
`ifdef SPIKE_HS_RX_SYNC3_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_i = 1'b0;
    logic [7:0] data_i = '0;
    logic       ack_o;
    logic       out_valid_o;
    logic       out_ready_i = 1'b0;
    logic [7:0] out_data_o;
    logic [2:0] fill_o;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    spike_hs_rx #(.DATA_W(8), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .data_i      (data_i),
        .ack_o       (ack_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .fill_o      (fill_o)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input logic val, input string tag);
        for (int i = 0; i < 60 && ack_o !== val; i++) tick;
        check(tag, 32'(ack_o), 32'(val));
    endtask

    task automatic send(input logic [7:0] d);
        data_i = d;
        req_i  = 1'b1;
        wait_ack(1'b1, "send_ack_hi");
        exp_q.push_back(d);
        req_i = 1'b0;
        wait_ack(1'b0, "send_ack_lo");
    endtask

    task automatic pop_one;
        check("pop_valid", 32'(out_valid_o), 32'd1);
        check("pop_data", 32'(out_data_o), 32'(exp_q[0]));
        out_ready_i = 1'b1;
        tick;
        out_ready_i = 1'b0;
        void'(exp_q.pop_front());
        check("pop_fill", 32'(fill_o), 32'(exp_q.size()));
    endtask

    initial begin
        int ph, gap, sent, pre_size;
        logic prev_ack, rdy;
        logic [7:0] d;
        tick;
        check("rst_ack", 32'(ack_o), 32'd0);
        check("rst_valid", 32'(out_valid_o), 32'd0);
        check("rst_fill", 32'(fill_o), 32'd0);
        rst = 1'b0;
        tick;

        // single transfer with exact ack latency both ways
        data_i = 8'hA5;
        req_i  = 1'b1;
        repeat (LAT - 1) tick;
        check("lat_rise_early", 32'(ack_o), 32'd0);
        tick;
        check("lat_rise", 32'(ack_o), 32'd1);
        exp_q.push_back(8'hA5);
        req_i = 1'b0;
        repeat (LAT - 1) tick;
        check("lat_fall_early", 32'(ack_o), 32'd1);
        tick;
        check("lat_fall", 32'(ack_o), 32'd0);
        check("single_valid", 32'(out_valid_o), 32'd1);
        check("single_data", 32'(out_data_o), 32'hA5);
        check("single_fill", 32'(fill_o), 32'd1);
        pop_one;

        // pop request while empty must be ignored
        out_ready_i = 1'b1;
        repeat (3) tick;
        out_ready_i = 1'b0;
        check("empty_pop_fill", 32'(fill_o), 32'd0);
        check("empty_pop_valid", 32'(out_valid_o), 32'd0);

        // fill to capacity, fifth request is backpressured
        for (int i = 1; i <= 4; i++) send(8'(i));
        check("full_fill", 32'(fill_o), 32'd4);
        data_i = 8'd5;
        req_i  = 1'b1;
        repeat (LAT + 6) tick;
        check("full_no_ack", 32'(ack_o), 32'd0);
        check("full_fill_hold", 32'(fill_o), 32'd4);
        pop_one;
        wait_ack(1'b1, "full_late_ack");
        exp_q.push_back(8'd5);
        req_i = 1'b0;
        wait_ack(1'b0, "full_late_ack_lo");
        while (exp_q.size() > 0) pop_one;

        // simultaneous push and pop at fill 2
        send(8'($urandom));
        send(8'($urandom));
        d = 8'($urandom);
        data_i = d;
        req_i  = 1'b1;
        repeat (LAT - 1) tick;
        check("sim_head", 32'(out_data_o), 32'(exp_q[0]));
        out_ready_i = 1'b1;
        tick;
        out_ready_i = 1'b0;
        check("sim_ack", 32'(ack_o), 32'd1);
        void'(exp_q.pop_front());
        exp_q.push_back(d);
        check("sim_fill", 32'(fill_o), 32'd2);
        req_i = 1'b0;
        wait_ack(1'b0, "sim_ack_lo");
        while (exp_q.size() > 0) pop_one;

        // randomized sender gaps, payloads and consumer readiness
        ph = 0; gap = 0; sent = 0; d = '0;
        for (int c = 0; c < 800; c++) begin
            if (ph == 0) begin
                if (gap == 0) begin
                    d = 8'($urandom);
                    data_i = d;
                    req_i = 1'b1;
                    ph = 1;
                end else gap--;
            end else if (ph == 1 && ack_o) begin
                req_i = 1'b0;
                ph = 2;
            end else if (ph == 2 && !ack_o) begin
                ph = 0;
                gap = $urandom_range(0, 3);
            end
            out_ready_i = ($urandom_range(0, 2) == 0);
            pre_size = exp_q.size();
            prev_ack = ack_o;
            rdy = out_ready_i;
            tick;
            if (rdy && pre_size > 0) void'(exp_q.pop_front());
            if (ack_o && !prev_ack) begin
                check("rnd_space", 32'(pre_size < DEPTH), 32'd1);
                exp_q.push_back(d);
                sent++;
            end
            check("rnd_fill", 32'(fill_o), 32'(exp_q.size()));
            check("rnd_valid", 32'(out_valid_o), 32'(exp_q.size() > 0));
            if (exp_q.size() > 0) check("rnd_data", 32'(out_data_o), 32'(exp_q[0]));
        end
        out_ready_i = 1'b0;
        check("rnd_progress", 32'(sent > 20), 32'd1);
        if (ph == 1) wait_ack(1'b1, "rnd_tail_ack");
        if (ph == 1) exp_q.push_back(d);
        req_i = 1'b0;
        wait_ack(1'b0, "rnd_tail_ack_lo");
        while (exp_q.size() > 0) pop_one;

        // asynchronous reset in the middle of a handshake
        send(8'h11);
        send(8'h22);
        data_i = 8'h33;
        req_i  = 1'b1;
        wait_ack(1'b1, "mid_ack_hi");
        check("mid_fill", 32'(fill_o), 32'd3);
        #2 rst = 1'b1;
        #1;
        check("arst_ack", 32'(ack_o), 32'd0);
        check("arst_valid", 32'(out_valid_o), 32'd0);
        check("arst_fill", 32'(fill_o), 32'd0);
        exp_q.delete();
        tick;
        tick;
        rst = 1'b0;
        // req_i still high after reset is a fresh request
        data_i = 8'h44;
        repeat (LAT - 1) tick;
        check("post_rst_early", 32'(ack_o), 32'd0);
        tick;
        check("post_rst_ack", 32'(ack_o), 32'd1);
        check("post_rst_fill", 32'(fill_o), 32'd1);
        check("post_rst_data", 32'(out_data_o), 32'h44);
        req_i = 1'b0;
        wait_ack(1'b0, "post_rst_ack_lo");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spike_hs_rx.md
SPIKE_HS_RX -- requirements
Module: spike_hs_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of the spike payload.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, receive buffer entries; power of two, at least 2.
REQ-003 SHALL have port clk  input  1  receive clock, rising-edge active.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port req_i  input  1  4-phase request from the asynchronous Muller-pipeline sender; asynchronous to clk.
REQ-006 SHALL have port data_i  input  DATA_W  bundled-data payload; sender holds it stable from before the req_i rise until ack_o rises.
REQ-007 SHALL have port ack_o  output  1  4-phase acknowledge to the sender; registered.
REQ-008 SHALL have port out_valid_o  output  1  buffered spike available.
REQ-009 SHALL have port out_ready_i  input  1  consumer accepts the head entry.
REQ-010 SHALL have port out_data_o  output  DATA_W  head entry of the buffer.
REQ-011 SHALL have port fill_o  output  $clog2(FIFO_DEPTH)+1  current occupancy.

Function
REQ-012 SHALL pass req_i through the synchronizer to produce req_s: 2 flops by default, 3 flops under REQ-026.
REQ-013 SHALL implement the FSM with states IDLE (ack_o=0) and ACK_HI (ack_o=1).
REQ-014 In IDLE with req_s=1 and fill_o<FIFO_DEPTH, SHALL write data_i to the FIFO on that edge and move to ACK_HI, so ack_o=1 the next cycle.
REQ-015 In IDLE with req_s=1 and FIFO full, SHALL stay in IDLE, write nothing, and hold ack_o=0 (backpressure); SHALL accept once space frees.
REQ-016 In ACK_HI, SHALL hold ack_o=1 while req_s=1; on req_s=0, SHALL return to IDLE with ack_o=0 the next cycle.
REQ-017 With the default synchronizer, SHALL raise ack_o 3 rising clk edges after a req_i rise sampled at an edge, given space in the FIFO.
REQ-018 SHALL capture exactly one entry per 4-phase cycle; a new capture requires req_s to return low first.
REQ-019 SHALL assert out_valid_o exactly when fill_o>0; out_data_o is the oldest entry and is don't-care when out_valid_o=0.
REQ-020 SHALL pop on clk when out_valid_o & out_ready_i; out_ready_i while empty SHALL have no effect.
REQ-021 SHALL update fill_o registered: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-022 SHALL wrap read and write pointers modulo FIFO_DEPTH; there is no write-through bypass, so a pushed entry appears on out_valid_o the cycle after the write.

Reset
REQ-023 While rst=1, SHALL force state=IDLE, ack_o=0, out_valid_o=0, fill_o=0, pointers=0 and synchronizer flops=0, asynchronously.
REQ-024 Reset mid-handshake SHALL discard the buffered entries and drop ack_o immediately.
REQ-025 If req_i is still high after rst deasserts, SHALL treat it as a new request; the sender must be reset together with this block.

Configuration
REQ-026 With macro SPIKE_HS_RX_SYNC3_EN defined, SHALL use a 3-flop synchronizer (ack_o rise latency 4 edges); without it, 2 flops (latency 3 edges).

Structure
REQ-027 SHALL take the FSM state enum typedef (IDLE, ACK_HI) and the default DATA_W/FIFO_DEPTH constants from shared package spike_hs_pkg.
REQ-028 SHALL implement the synchronizer as sub-module spike_hs_sync (asynchronous reset to 0, depth selected by REQ-026); the FIFO stays inline.

Verification
REQ-029 Single transfer: req_i rises with data_i=8'hA5 and out_ready_i=0 -> ack_o=1 at edge 3; after req_i falls, ack_o=0 3 edges later; out_valid_o=1, out_data_o=8'hA5, fill_o=1.
REQ-030 Fill: 5 transfers with FIFO_DEPTH=4 and out_ready_i=0 -> the 5th ack_o stays 0 and fill_o=4; one pop -> the 5th is acked, and the FIFO reads back 1..5 in order.
REQ-031 Simultaneous push and pop at fill_o=2 -> fill_o stays 2, data order preserved.
REQ-032 Reset asserted while ack_o=1 with fill_o=3 -> ack_o, out_valid_o and fill_o go to 0 in the same cycle, without waiting for a clock edge.
REQ-033 With SPIKE_HS_RX_SYNC3_EN defined -> ack_o rises at edge 4; pop with out_ready_i=1 while empty -> fill_o stays 0.
